// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq -- sequential binary-to-BCD converter (shift-add-3, one bit/clock)
//
// Converts an unsigned WIDTH-bit value into four BCD digits for the 4-digit
// seven-segment multiplexer (bcd0 = rightmost ... bcd3 = leftmost). Values
// above MAX_VAL show 4'hF on every digit, so the decoder displays dashes.
//
// Ports
//   clock   in   1      system clock, rising edge
//   reset   in   1      asynchronous, active-low reset
//   start   in   1      request conversion of bin (ignored while busy)
//   bin     in   WIDTH  unsigned value, captured on the accepting edge only
//   busy    out  1      conversion in progress
//   done    out  1      one-cycle pulse; bcd0..bcd3 and ovf valid from here
//   ovf     out  1      last accepted bin was > MAX_VAL
//   bcd0..3 out  4      ones / tens / hundreds / thousands digit
//
// Timing: start accepted at edge E0 -> done high after edge E0+WIDTH+1,
// independent of the value. Outputs only change at the FINISH edge or reset.
// -----------------------------------------------------------------------------

// Per-digit correction: a nibble of 5..9 becomes 8..12 so that the following
// left shift carries into the next decade.
module bin2bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end
endmodule

module bin2bcd_seq #(
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       bcd0,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd3
);

  localparam int NDIG = 4;
  localparam int CW   = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t                     state, state_nxt;
  logic [WIDTH-1:0]           shreg;
  logic [NDIG-1:0][3:0]       scratch;
  logic [NDIG-1:0][3:0]       adj;
  logic [NDIG-1:0][3:0]       bcd_q;
  logic [CW-1:0]              cnt;
  // Range check is decided at capture time on the full input width, so the
  // truncated scratch contents of an out-of-range value never reach the display.
  logic                       ovf_pend;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      bin2bcd_add3 u_add3 (
        .din  (scratch[gi]),
        .dout (adj[gi])
      );
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(WIDTH-1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      bcd_q    <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= bin;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= (bin > WIDTH'(MAX_VAL));
          end
        end
        SHIFT: begin
          // correct then shift: the corrected digits move up with the next bit
          {scratch, shreg} <= {adj, shreg} << 1;
          cnt              <= cnt + 1'b1;
        end
        FINISH: begin
          done <= 1'b1;
          ovf  <= ovf_pend;
          bcd_q <= ovf_pend ? {NDIG{4'hF}} : scratch;
        end
        default: ;
      endcase
    end
  end

  // busy covers SHIFT and FINISH; done rises as the FSM returns to IDLE,
  // so the two are never high in the same cycle.
  assign busy = (state != IDLE);
  assign bcd0 = bcd_q[0];
  assign bcd1 = bcd_q[1];
  assign bcd2 = bcd_q[2];
  assign bcd3 = bcd_q[3];

endmodule
